// File: rtl/fast_ctrl_pkg.sv
// Shared constants, FSM state encoding and the saturating drop-count helper
// for the fast-control command scheduler.
package fast_ctrl_pkg;

  localparam int unsigned ORBIT_LEN_DEF    = 3564;
  localparam int unsigned BX_W             = 12;
  localparam int unsigned HOLDOFF_DEF      = 16;
  localparam int unsigned ABORT_ORBITS_DEF = 2;
  localparam int unsigned DROP_W           = 8;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StWaitQrst = 2'd1,
    StWaitWte  = 2'd2,
    StHoldoff  = 2'd3
  } fc_state_e;

  function automatic logic [DROP_W-1:0] drop_sat_add(input logic [DROP_W-1:0] cnt,
                                                     input logic [1:0]        inc);
    logic [DROP_W:0] sum;
    sum = {1'b0, cnt} + {{(DROP_W-1){1'b0}}, inc};
    return sum[DROP_W] ? '1 : sum[DROP_W-1:0];
  endfunction

endpackage

// File: rtl/fc_edge_detect.sv
// Registers a request line and flags its rising edge. A line held high through
// reset is ignored until it has been seen low at least once.
module fc_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic req,
  output logic rise
);

  logic req_r;
  logic req_prev;
  logic armed;

  always_ff @(posedge clk) begin
    if (reset) begin
      req_r    <= 1'b0;
      req_prev <= 1'b0;
      armed    <= ~req;
    end else begin
      req_r    <= req;
      req_prev <= req_r;
      if (!req) begin
        armed <= 1'b1;
      end
    end
  end

  assign rise = armed & req_r & ~req_prev;

endmodule

// File: rtl/fast_cmd_scheduler.sv
// Schedules QIE-reset and WTE commands onto a programmable bunch crossing,
// with a post-issue holdoff, an orbit-count abort and a saturating drop counter.
module fast_cmd_scheduler
  import fast_ctrl_pkg::*;
#(
  parameter int unsigned ORBIT_LEN    = ORBIT_LEN_DEF,
  parameter int unsigned HOLDOFF      = HOLDOFF_DEF,  // must be >= 1
  parameter int unsigned ABORT_ORBITS = ABORT_ORBITS_DEF  // must be >= 1
) (
  input  logic              clk,
  input  logic              reset_in,
  input  logic              bc0_in,
  input  logic              qrst_req_in,
  input  logic              wte_req_in,
  input  logic [BX_W-1:0]   qrst_bx_in,
  input  logic [BX_W-1:0]   wte_bx_in,
  output logic              qie_reset_out,
  output logic              wte_out,
  output logic [BX_W-1:0]   bx_count_out,
  output logic              busy_out,
  output logic [DROP_W-1:0] drop_count_out
);

  localparam int unsigned HW = $clog2(HOLDOFF + 1);
  localparam int unsigned AW = $clog2(ABORT_ORBITS + 1);
  localparam logic [BX_W-1:0] BX_LAST    = BX_W'(ORBIT_LEN - 1);
  localparam logic [HW-1:0]   HOLD_LOAD  = HW'(HOLDOFF - 1);
  localparam logic [AW-1:0]   ABORT_LAST = AW'(ABORT_ORBITS - 1);

  fc_state_e       state;
  logic            qrst_pend;
  logic            wte_pend;
  logic [HW-1:0]   hold_cnt;
  logic [AW-1:0]   abort_cnt;

  logic            qrst_rise;
  logic            wte_rise;
  logic            wrap;
  logic            qrst_hit;
  logic            wte_hit;
  logic            abort_due;
  logic            qrst_abort;
  logic            wte_abort;
  logic            qrst_clr;
  logic            wte_clr;
  logic            qrst_drop;
  logic            wte_drop;
  logic [1:0]      drop_inc;

  fc_edge_detect u_qrst_edge (
    .clk   (clk),
    .reset (reset_in),
    .req   (qrst_req_in),
    .rise  (qrst_rise)
  );

  fc_edge_detect u_wte_edge (
    .clk   (clk),
    .reset (reset_in),
    .req   (wte_req_in),
    .rise  (wte_rise)
  );

  always_comb begin
    wrap       = bc0_in | (bx_count_out == BX_LAST);
    qrst_hit   = (state == StWaitQrst) & (bx_count_out == qrst_bx_in);
    wte_hit    = (state == StWaitWte) & (bx_count_out == wte_bx_in);
    abort_due  = wrap & (abort_cnt == ABORT_LAST);
    qrst_abort = (state == StWaitQrst) & ~qrst_hit & abort_due;
    wte_abort  = (state == StWaitWte) & ~wte_hit & abort_due;
    qrst_clr   = qrst_hit | qrst_abort;
    wte_clr    = wte_hit | wte_abort;
    // A new edge coinciding with the flag clearing re-arms it instead of dropping.
    qrst_drop  = qrst_rise & qrst_pend & ~qrst_clr;
    wte_drop   = wte_rise & wte_pend & ~wte_clr;
    drop_inc   = {1'b0, qrst_drop} + {1'b0, wte_drop} + {1'b0, qrst_abort | wte_abort};
  end

  always_ff @(posedge clk) begin
    if (reset_in) begin
      state          <= StIdle;
      busy_out       <= 1'b0;
      bx_count_out   <= '0;
      qrst_pend      <= 1'b0;
      wte_pend       <= 1'b0;
      hold_cnt       <= '0;
      abort_cnt      <= '0;
      drop_count_out <= '0;
      qie_reset_out  <= 1'b0;
      wte_out        <= 1'b0;
    end else begin
      bx_count_out   <= wrap ? '0 : bx_count_out + BX_W'(1);
      qrst_pend      <= qrst_rise | (qrst_pend & ~qrst_clr);
      wte_pend       <= wte_rise | (wte_pend & ~wte_clr);
      drop_count_out <= drop_sat_add(drop_count_out, drop_inc);
      qie_reset_out  <= qrst_hit;
      wte_out        <= wte_hit;

      case (state)
        StIdle: begin
          abort_cnt <= '0;
          if (qrst_pend) begin
            state    <= StWaitQrst;
            busy_out <= 1'b1;
          end else if (wte_pend) begin
            state    <= StWaitWte;
            busy_out <= 1'b1;
          end
        end
        StWaitQrst, StWaitWte: begin
          if (qrst_hit | wte_hit) begin
            state    <= StHoldoff;
            hold_cnt <= HOLD_LOAD;
          end else if (qrst_abort | wte_abort) begin
            state    <= StIdle;
            busy_out <= 1'b0;
          end else if (wrap) begin
            abort_cnt <= abort_cnt + AW'(1);
          end
        end
        StHoldoff: begin
          if (hold_cnt == '0) begin
            state    <= StIdle;
            busy_out <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt - HW'(1);
          end
        end
        default: begin
          state    <= StIdle;
          busy_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/fast_cmd_scheduler.md
FAST_CMD_SCHEDULER -- requirements
Module: fast_cmd_scheduler

Interface
REQ-001 Parameter ORBIT_LEN, default 3564: bunch crossings per orbit; bx counter wraps at ORBIT_LEN-1.
REQ-002 Parameter HOLDOFF, default 16: idle cycles enforced after any issued command.
REQ-003 Parameter ABORT_ORBITS, default 2: orbit wraps in a WAIT state before the pending command is aborted.
REQ-004 clk  in  1  sole clock; all logic on posedge clk.
REQ-005 reset_in  in  1  synchronous, active-high reset.
REQ-006 bc0_in  in  1  orbit marker; high forces bx counter to 0 on next edge.
REQ-007 qrst_req_in  in  1  QIE-reset request; rising edge is the request.
REQ-008 wte_req_in  in  1  WTE request; rising edge is the request.
REQ-009 qrst_bx_in  in  12  BX at which QIE reset is issued.
REQ-010 wte_bx_in  in  12  BX at which WTE is issued.
REQ-011 qie_reset_out  out  1  one-cycle QIE-reset pulse.
REQ-012 wte_out  out  1  one-cycle WTE pulse.
REQ-013 bx_count_out  out  12  current bx counter value.
REQ-014 busy_out  out  1  high whenever state is not IDLE.
REQ-015 drop_count_out  out  8  saturating count of dropped or aborted requests.

Function
REQ-016 Bx counter: +1 per cycle, ORBIT_LEN-1 -> 0 wrap; bc0_in=1 loads 0 (overrides increment).
REQ-017 Request inputs registered once, then edge-detected (previous-sample low, current high); edge latency 2 cycles from input rise to pending flag set.
REQ-018 One pending flag per command (qrst_pend, wte_pend); edge while flag already set -> request dropped, drop_count +1.
REQ-019 drop_count saturates at 255; never wraps.
REQ-020 FSM states IDLE, WAIT_QRST, WAIT_WTE, HOLDOFF.
REQ-021 IDLE: qrst_pend -> WAIT_QRST; else wte_pend -> WAIT_WTE; else stay. QRST has strict priority.
REQ-022 WAIT_QRST: when bx_count_out == qrst_bx_in, qie_reset_out = 1 the following cycle only, qrst_pend cleared, -> HOLDOFF.
REQ-023 WAIT_WTE: same as REQ-022 using wte_bx_in, wte_out, wte_pend.
REQ-024 Target BX sampled each cycle (not latched); changing it mid-WAIT takes effect immediately.
REQ-025 HOLDOFF: stays exactly HOLDOFF cycles, then -> IDLE; requests during HOLDOFF are latched as pending, not dropped.
REQ-026 Abort: in a WAIT state, ABORT_ORBITS counter wraps (ORBIT_LEN-1 -> 0 or bc0_in) without match -> clear that pend flag, drop_count +1, -> IDLE. Covers targets >= ORBIT_LEN.
REQ-027 Edge of a command in the same cycle its pend flag clears on issue: set wins; new request stays pending.
REQ-028 qie_reset_out and wte_out never high in the same cycle; each high at most one cycle per issue.

Reset
REQ-029 reset_in=1 at edge: state IDLE, bx counter 0, both pend flags 0, edge-detect history 0, drop_count 0, abort counter 0.
REQ-030 All outputs 0 the cycle after reset_in sampled high; reset mid-WAIT or mid-HOLDOFF discards pending commands, no pulse issued.
REQ-031 Request held high through reset release: no edge seen until it goes low then high again.

Structure
REQ-032 Package fast_ctrl_pkg: ORBIT_LEN default, BX_W=12, HOLDOFF default, FSM state encoding.
REQ-033 One sub-module fc_edge_detect (register + rising-edge pulse), instantiated twice.
REQ-034 Bx counter, FSM, holdoff/abort counters and drop counter in fast_cmd_scheduler; all outputs registered.

Verification
REQ-035 qrst_bx_in=100, qrst_req_in rises at BX 10 -> qie_reset_out high once at BX 101; busy_out low 16 cycles later.
REQ-036 qrst_req_in and wte_req_in rise same cycle, both targets 50 -> qie_reset_out at BX 51 this orbit, wte_out at BX 51 next orbit.
REQ-037 Three qrst edges while pending -> drop_count_out=2, single qie_reset_out pulse; 300 dropped edges -> 255.
REQ-038 qrst_bx_in=4000 -> no pulse, after 2 orbit wraps state IDLE, drop_count_out +1.
REQ-039 bc0_in at BX 2000 -> bx_count_out=0 next cycle; pending target 10 issues after 11 cycles.
REQ-040 reset_in pulsed during WAIT_WTE -> no wte_out, all outputs 0, bx_count_out restarts at 0.
